// File: rtl/non_restoring_division_result_stage.sv
// non_restoring_division_result_stage
//
// Final stage of the non-restoring divider. It accepts the raw partial
// remainder A and quotient magnitude Q once the iteration loop has finished.
// It then applies the closing remainder correction, restores the signs for
// signed division, flags divide-by-zero and the signed overflow case, and
// holds the registered result until the consumer takes it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   raw_valid/ready   handshake from the divider core (ready only in IDLE)
//   raw_A             final partial remainder, N+1 bits, two's complement
//   raw_Q             unsigned quotient magnitude
//   divisor_mag       unsigned divisor magnitude M
//   dividend_in       original dividend (returned as remainder on /0)
//   signed_mode       1 = signed division
//   dividend_sign     sign of original dividend (signed mode only)
//   divisor_sign      sign of original divisor (signed mode only)
//   result_valid/ready handshake toward the consumer
//   quotient, remainder, div_by_zero, overflow   registered results
//   busy              high whenever the stage is not IDLE
module non_restoring_division_result_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         raw_valid,
    output logic         raw_ready,
    input  logic [N:0]   raw_A,
    input  logic [N-1:0] raw_Q,
    input  logic [N-1:0] divisor_mag,
    input  logic [N-1:0] dividend_in,
    input  logic         signed_mode,
    input  logic         dividend_sign,
    input  logic         divisor_sign,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CORRECT = 2'd1;
    localparam logic [1:0] SIGN    = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    // Two's complement negation modulo 2^N.
    function automatic logic [N-1:0] negate(input logic [N-1:0] v);
        return (~v) + ONE;
    endfunction

    // A negative final partial remainder is one divisor short of the true
    // remainder; add M back (modulo 2^(N+1)) and keep the low N bits.
    function automatic logic [N-1:0] fix_remainder(input logic [N:0] a,
                                                   input logic [N-1:0] m);
        logic [N:0] sum;
        sum = a + {1'b0, m};
        return a[N] ? sum[N-1:0] : a[N-1:0];
    endfunction

    logic [1:0]   state;

    // Captured raw result and operand context
    logic [N:0]   a_cap;
    logic [N-1:0] q_cap;
    logic [N-1:0] m_cap;
    logic [N-1:0] dividend_cap;
    logic         smode_cap;
    logic         dsign_cap;
    logic         vsign_cap;

    // Corrected magnitudes
    logic [N-1:0] rem_reg;
    logic [N-1:0] q_reg;
    logic         dbz_reg;

    // Sign-stage results
    logic [N-1:0] q_next;
    logic [N-1:0] r_next;
    logic         dbz_next;
    logic         ovf_next;

    assign raw_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == OUT);

    // Result selection, first matching case wins; divide-by-zero overrides
    // everything, and the overflow case also pins the remainder to zero.
    always_comb begin
        q_next   = q_reg;
        r_next   = (smode_cap && dsign_cap) ? negate(rem_reg) : rem_reg;
        dbz_next = 1'b0;
        ovf_next = 1'b0;
        if (dbz_reg) begin
            q_next   = '1;
            r_next   = dividend_cap;
            dbz_next = 1'b1;
        end else if (smode_cap && (dsign_cap != vsign_cap)) begin
            q_next = negate(q_reg);
        end else if (smode_cap && (q_reg == MOST_NEG)) begin
            q_next   = MOST_NEG;
            r_next   = '0;
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state)
                // IDLE -> CORRECT: capture the raw core result
                IDLE: begin
                    if (raw_valid) begin
                        a_cap        <= raw_A;
                        q_cap        <= raw_Q;
                        m_cap        <= divisor_mag;
                        dividend_cap <= dividend_in;
                        smode_cap    <= signed_mode;
                        dsign_cap    <= dividend_sign;
                        vsign_cap    <= divisor_sign;
                        state        <= CORRECT;
                    end
                end
                // CORRECT -> SIGN: remainder correction, zero-divisor detect
                CORRECT: begin
                    q_reg   <= q_cap;
                    dbz_reg <= (m_cap == '0);
                    rem_reg <= (m_cap == '0) ? a_cap[N-1:0]
                                             : fix_remainder(a_cap, m_cap);
                    state   <= SIGN;
                end
                // SIGN -> OUT: register final results
                SIGN: begin
                    quotient    <= q_next;
                    remainder   <= r_next;
                    div_by_zero <= dbz_next;
                    overflow    <= ovf_next;
                    state       <= OUT;
                end
                // OUT -> IDLE: hold until the consumer accepts
                OUT: begin
                    if (result_ready) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_non_restoring_division_result_stage.sv
// Testbench for non_restoring_division_result_stage (N = 8). Expected
// results are pushed to a scoreboard queue when a raw result is driven and
// popped when the stage presents its output.
module tb_non_restoring_division_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_valid;
    logic       raw_ready;
    logic [8:0] raw_A;
    logic [7:0] raw_Q;
    logic [7:0] divisor_mag;
    logic [7:0] dividend_in;
    logic       signed_mode;
    logic       dividend_sign;
    logic       divisor_sign;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;
    logic       busy;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    non_restoring_division_result_stage #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_valid    (raw_valid),
        .raw_ready    (raw_ready),
        .raw_A        (raw_A),
        .raw_Q        (raw_Q),
        .divisor_mag  (divisor_mag),
        .dividend_in  (dividend_in),
        .signed_mode  (signed_mode),
        .dividend_sign(dividend_sign),
        .divisor_sign (divisor_sign),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: true integer division on the original operands.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sm);
        exp_t e;
        int   sa;
        int   sbv;
        e = '0;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else if (!sm) begin
            e.q = a / b; e.r = a % b;
        end else begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            if (sa == -128 && sbv == -1) begin
                e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1;
            end else begin
                e.q = 8'(sa / sbv); e.r = 8'(sa % sbv);
            end
        end
        return e;
    endfunction

    task automatic set_raw(input logic [8:0] a, input logic [7:0] q,
                           input logic [7:0] m, input logic [7:0] dvd,
                           input logic sm, input logic ds, input logic vs);
        raw_A = a; raw_Q = q; divisor_mag = m; dividend_in = dvd;
        signed_mode = sm; dividend_sign = ds; divisor_sign = vs;
    endtask

    // Present a raw result for one accept edge; returns at the next negedge.
    task automatic drive_raw(input logic [8:0] a, input logic [7:0] q,
                             input logic [7:0] m, input logic [7:0] dvd,
                             input logic sm, input logic ds, input logic vs);
        set_raw(a, q, m, dvd, sm, ds, vs);
        raw_valid = 1'b1;
        @(negedge clk);
        raw_valid = 1'b0;
    endtask

    // Emulate the divider core on random operands, load its raw outputs and
    // push the expected final result.
    task automatic gen_random();
        logic [7:0] a, b, ma, mb, qq, rr;
        logic [8:0] ra;
        logic       sm;
        int         sel;
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
        sel = int'($urandom % 8);
        if (sel == 0) b = 8'd0;
        if (sel == 1) begin a = 8'h80; b = 8'hFF; sm = 1'b1; end
        ma = (sm && a[7]) ? 8'(-a) : a;
        mb = (sm && b[7]) ? 8'(-b) : b;
        if (mb == 8'd0) begin
            qq = 8'($urandom); ra = 9'($urandom);
        end else begin
            qq = ma / mb; rr = ma % mb;
            ra = ($urandom % 2 == 0) ? {1'b0, rr} : ({1'b0, rr} - {1'b0, mb});
        end
        set_raw(ra, qq, mb, a, sm, sm ? a[7] : 1'($urandom),
                sm ? b[7] : 1'($urandom));
        sb.push_back(model(a, b, sm));
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({raw_ready, busy, result_valid, quotient, remainder, div_by_zero, overflow}
            !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b busy=%b vld=%b q=%h r=%h dbz=%b ovf=%b want rdy=1 busy=0 vld=0 q=00 r=00 dbz=0 ovf=0",
                     raw_ready, busy, result_valid, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_unsigned();
        exp_t e;
        bit   ok;
        sb.push_back('{q: 8'd14, r: 8'd2, dbz: 1'b0, ovf: 1'b0});
        drive_raw(9'd2, 8'd14, 8'd7, 8'd100, 1'b0, 1'b0, 1'b0);
        total++;
        if ({busy, raw_ready, result_valid} !== 3'b100) begin
            bad++;
            $display("FAIL latency_edge1: got busy=%b rdy=%b vld=%b want 1 0 0", busy, raw_ready, result_valid);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_edge2: got vld=%b want 0", result_valid);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency_edge3: got vld=%b want 1", result_valid);
        end
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
            bad++;
            $display("FAIL unsigned_100_7: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        release_result();
        total++;
        if ({result_valid, raw_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL release_to_idle: got vld=%b rdy=%b busy=%b want 0 1 0", result_valid, raw_ready, busy);
        end
    endtask

    task automatic test_neg_remainder();
        exp_t e;
        bit   ok;
        sb.push_back('{q: 8'd3, r: 8'd1, dbz: 1'b0, ovf: 1'b0});
        drive_raw(9'h1FD, 8'd3, 8'd4, 8'd13, 1'b0, 1'b0, 1'b0);
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
            bad++;
            $display("FAIL neg_remainder: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        release_result();
    endtask

    task automatic test_signed();
        exp_t e;
        bit   ok;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) sb.push_back('{q: 8'hFD, r: 8'hFF, dbz: 1'b0, ovf: 1'b0});
            else        sb.push_back('{q: 8'h03, r: 8'hFF, dbz: 1'b0, ovf: 1'b0});
            drive_raw(9'd1, 8'd3, 8'd2, 8'hF9, 1'b1, 1'b1, 1'(k));
            wait_valid(ok);
            e = sb.pop_front();
            total++;
            if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
                bad++;
                $display("FAIL signed_m7_div_%s: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                         (k == 0) ? "p2" : "m2", quotient, remainder, div_by_zero, overflow,
                         e.q, e.r, e.dbz, e.ovf);
            end
            release_result();
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        bit   ok;
        sb.push_back('{q: 8'hFF, r: 8'h2A, dbz: 1'b1, ovf: 1'b0});
        drive_raw(9'h155, 8'h5A, 8'd0, 8'h2A, 1'b1, 1'b0, 1'b1);
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
            bad++;
            $display("FAIL div_by_zero: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        release_result();
        total++;
        if ({div_by_zero, overflow, result_valid} !== 3'b000) begin
            bad++;
            $display("FAIL dbz_flag_clear: got dbz=%b ovf=%b vld=%b want 0 0 0", div_by_zero, overflow, result_valid);
        end
    endtask

    task automatic test_overflow_backpressure();
        exp_t e;
        bit   ok;
        sb.push_back('{q: 8'h80, r: 8'h00, dbz: 1'b0, ovf: 1'b1});
        drive_raw(9'd0, 8'h80, 8'd1, 8'h80, 1'b1, 1'b1, 1'b1);
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
            bad++;
            $display("FAIL overflow: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                set_raw(9'd5, 8'd9, 8'd7, 8'd68, 1'b0, 1'b0, 1'b0);
                raw_valid = 1'b1;
            end
            @(negedge clk);
            raw_valid = 1'b0;
            total++;
            if ({result_valid, raw_ready, quotient, remainder, div_by_zero, overflow}
                !== {1'b1, 1'b0, e.q, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b q=%h r=%h dbz=%b ovf=%b want vld=1 rdy=0 q=%h r=%h dbz=%b ovf=%b",
                         c, result_valid, raw_ready, quotient, remainder, div_by_zero, overflow,
                         e.q, e.r, e.dbz, e.ovf);
            end
        end
        release_result();
        @(negedge clk);
        total++;
        if ({busy, result_valid, raw_ready, overflow} !== 4'b0010) begin
            bad++;
            $display("FAIL ignored_raw_valid: got busy=%b vld=%b rdy=%b ovf=%b want 0 0 1 0",
                     busy, result_valid, raw_ready, overflow);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        drive_raw(9'd3, 8'd21, 8'd5, 8'd108, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({result_valid, raw_ready, busy, quotient, remainder}
            !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid: got vld=%b rdy=%b busy=%b q=%h r=%h want vld=0 rdy=1 busy=0 q=00 r=00",
                     result_valid, raw_ready, busy, quotient, remainder);
        end
        sb.push_back('{q: 8'd8, r: 8'd2, dbz: 1'b0, ovf: 1'b0});
        drive_raw(9'd2, 8'd8, 8'd6, 8'd50, 1'b0, 1'b0, 1'b0);
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
            bad++;
            $display("FAIL after_reset: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        gen_random();
        raw_valid = 1'b1;
        @(negedge clk);
        raw_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            wait_valid(ok);
            e = sb.pop_front();
            total++;
            if (!ok || {quotient, remainder, div_by_zero, overflow} !== e) begin
                bad++;
                $display("FAIL random_%0d: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                         t, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
            end
            if (t == 29) begin
                release_result();
            end else begin
                gen_random();
                raw_valid    = 1'b1;
                result_ready = 1'b1;
                @(negedge clk);
                result_ready = 1'b0;
                total++;
                if ({raw_ready, result_valid} !== 2'b10) begin
                    bad++;
                    $display("FAIL b2b_idle_%0d: got rdy=%b vld=%b want 1 0", t, raw_ready, result_valid);
                end
                @(negedge clk);
                raw_valid = 1'b0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_accept_%0d: got busy=%b want 1", t, busy);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        raw_valid    = 1'b0;
        result_ready = 1'b0;
        set_raw(9'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_neg_remainder();
        test_signed();
        test_div_by_zero();
        test_overflow_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
